// File: rtl/mx_int8_to_e4m3_if.sv
// Element stream bundle for the INT8 -> FP8 E4M3 converter (upstream and downstream handshakes).
// o_inexact exists only when MX_NORM_INEXACT_EN is defined.
interface mx_int8_to_e4m3_if;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
`ifdef MX_NORM_INEXACT_EN
  logic       o_inexact;
`endif

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
`ifdef MX_NORM_INEXACT_EN
    , output o_inexact
`endif
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
`ifdef MX_NORM_INEXACT_EN
    , input o_inexact
`endif
  );
endinterface

// File: rtl/mx_int8_to_e4m3.sv
// INT8 -> FP8 E4M3 (bias 7, RNE); 2-cycle latency, o_ready stalls only when both stages are full and i_ready is low.
// Optional o_inexact output enabled by defining MX_NORM_INEXACT_EN.
module mx_int8_to_e4m3 #(
  parameter bit SIGNED_IN = 1'b1
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mx_int8_to_e4m3_if.slave bus
);

  logic       s1_vld_q, s1_vld_d;
  logic       s1_sign_q, s1_sign_d;
  logic [7:0] s1_mag_q, s1_mag_d;
  logic [3:0] s1_lz_q, s1_lz_d;
  logic       s2_vld_q, s2_vld_d;
  logic [7:0] s2_dat_q, s2_dat_d;
`ifdef MX_NORM_INEXACT_EN
  logic       s2_inx_q, s2_inx_d;
`endif

  logic       in_acc;
  logic       s2_load;
  logic       neg;
  logic [7:0] mag;
  logic [3:0] lz;
  logic [7:0] shifted;
  logic [2:0] mant;
  logic       guard;
  logic       sticky;
  logic       round_up;
  logic [3:0] mant_inc;
  logic [3:0] exp_b;
  logic [7:0] result;

  assign bus.o_ready = !s1_vld_q || !s2_vld_q || bus.i_ready;
  assign bus.o_valid = s2_vld_q;
  assign bus.o_data  = s2_dat_q;
`ifdef MX_NORM_INEXACT_EN
  assign bus.o_inexact = s2_inx_q;
`endif

  assign in_acc  = bus.i_valid && bus.o_ready;
  assign s2_load = s1_vld_q && (!s2_vld_q || bus.i_ready);

  // Stage 1: sign, magnitude (-128 -> 128 fits in 8 bits), leading-zero count.
  always_comb begin
    neg = SIGNED_IN && bus.i_data[7];
    mag = neg ? (~bus.i_data + 8'd1) : bus.i_data;
    lz  = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (mag[i]) lz = 4'(7 - i);
    end
    s1_vld_d  = in_acc ? 1'b1 : (s2_load ? 1'b0 : s1_vld_q);
    s1_sign_d = in_acc ? neg : s1_sign_q;
    s1_mag_d  = in_acc ? mag : s1_mag_q;
    s1_lz_d   = in_acc ? lz  : s1_lz_q;
  end

  // Stage 2: normalise, round to nearest even; carry out of the mantissa bumps the exponent.
  always_comb begin
    shifted  = s1_mag_q << s1_lz_q;
    mant     = shifted[6:4];
    guard    = shifted[3];
    sticky   = |shifted[2:0];
    round_up = guard && (sticky || mant[0]);
    mant_inc = {1'b0, mant} + {3'b000, round_up};
    exp_b    = 4'd14 - s1_lz_q + {3'b000, mant_inc[3]};
    result   = {s1_sign_q, exp_b, mant_inc[2:0]};
    if (s1_mag_q == 8'd0) result = 8'h00;
    s2_vld_d = s2_load ? 1'b1 : (bus.i_ready ? 1'b0 : s2_vld_q);
    s2_dat_d = s2_load ? result : s2_dat_q;
`ifdef MX_NORM_INEXACT_EN
    s2_inx_d = s2_load ? (guard || sticky) : s2_inx_q;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= 8'd0;
      s1_lz_q   <= 4'd0;
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= 8'h00;
`ifdef MX_NORM_INEXACT_EN
      s2_inx_q  <= 1'b0;
`endif
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_lz_q   <= s1_lz_d;
      s2_vld_q  <= s2_vld_d;
      s2_dat_q  <= s2_dat_d;
`ifdef MX_NORM_INEXACT_EN
      s2_inx_q  <= s2_inx_d;
`endif
    end
  end

endmodule
